// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory request path:
// request field layout and the responder state encoding.
package cache_pkg;

  localparam int unsigned REQ_WIDTH = 33;
  localparam int unsigned WRITE_BIT = 32;
  localparam int unsigned DATA_MSB  = 31;
  localparam int unsigned DATA_LSB  = 16;
  localparam int unsigned ADDR_MSB  = 15;
  localparam int unsigned WORD_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } resp_state_e;

endpackage

// File: rtl/memory_array.sv
// Word storage for the responder: synchronous write, combinational read,
// every word cleared by the asynchronous active-low reset.
module memory_array
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WORD_W-1:0]    rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory model answering one cache request at a time with a
// 4-phase handshake; writes commit on acceptance and raise an invalidate pulse.
module memory_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REQ_WIDTH-1:0] memory_request,
  input  logic                 memory_request_ready,
  output logic [WORD_W-1:0]    memory_response,
  output logic                 memory_response_ready,
  output logic [WORD_W-1:0]    invalidate_address,
  output logic                 invalidate_valid
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  resp_state_e          state_q;
  logic [3:0]           cnt_q;
  logic                 wr_q;
  logic [WORD_W-1:0]    data_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_W-1:0]    rsp_q;
  logic                 rsp_vld_q;
  logic [WORD_W-1:0]    inv_addr_q;
  logic                 inv_vld_q;

  logic              req_wr;
  logic [WORD_W-1:0] req_data;
  logic [WORD_W-1:0] req_addr;
  logic              accept;
  logic [WORD_W-1:0] rd_word;

  assign req_wr   = memory_request[WRITE_BIT];
  assign req_data = memory_request[DATA_MSB:DATA_LSB];
  assign req_addr = memory_request[ADDR_MSB:0];
  assign accept   = (state_q == IDLE) && memory_request_ready;

  memory_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (accept && req_wr),
    .waddr_i(req_addr[ADDR_BITS-1:0]),
    .wdata_i(req_data),
    .raddr_i(addr_q),
    .rdata_o(rd_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      rsp_q      <= '0;
      rsp_vld_q  <= 1'b0;
      inv_addr_q <= '0;
      inv_vld_q  <= 1'b0;
    end else begin
      inv_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (memory_request_ready) begin
            wr_q   <= req_wr;
            data_q <= req_data;
            addr_q <= req_addr[ADDR_BITS-1:0];
            // LATENCY=1 also passes through WAIT, with a zero count, so the
            // registered ready lands exactly LATENCY edges after acceptance.
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
            if (req_wr) begin
              inv_vld_q  <= 1'b1;
              inv_addr_q <= req_addr;
            end
          end
        end
        WAIT: begin
          if (!memory_request_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q   <= RESPOND;
            rsp_vld_q <= 1'b1;
            rsp_q     <= wr_q ? data_q : rd_word;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESPOND: begin
          if (!memory_request_ready) begin
            state_q   <= IDLE;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memory_response       = rsp_q;
  assign memory_response_ready = rsp_vld_q;
  assign invalidate_address    = inv_addr_q;
  assign invalidate_valid      = inv_vld_q;

endmodule
